shift_load_ctrl: RTL and testbench



---
 rtl/shift_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_shift_load_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_load_ctrl.sv
// Serial-load sequencer for the sfr chain: accepts a word over valid/ready, streams
// it one bit per DIV-cycle shift period, then pulses a one-cycle latch strobe.
module shift_load_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_sd,
  output logic             o_shift_en,
  output logic             o_latch,
  output logic             o_busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             ready_q, ready_d;
  logic             sd_q, sd_d;
  logic             shen_q, shen_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;

  logic             first_bit, next_bit;
  logic [WIDTH-1:0] data_adv, shadow_adv;

  // The shadow register is pre-advanced so its outgoing end always holds the next bit.
  always_comb begin
    first_bit  = MSB_FIRST ? i_data[WIDTH-1] : i_data[0];
    next_bit   = MSB_FIRST ? shadow_q[WIDTH-1] : shadow_q[0];
    data_adv   = MSB_FIRST ? (i_data << 1) : (i_data >> 1);
    shadow_adv = MSB_FIRST ? (shadow_q << 1) : (shadow_q >> 1);
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    ready_d   = ready_q;
    sd_d      = sd_q;
    shen_d    = 1'b0;
    latch_d   = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        sd_d    = 1'b0;
        if (i_valid && ready_q) begin
          state_d   = S_SHIFT;
          shadow_d  = data_adv;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          sd_d      = first_bit;
          shen_d    = (DIV_LAST == '0);
        end
      end
      S_SHIFT: begin
        if (i_abort) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          sd_d      = 1'b0;
        end else if (div_cnt_q == DIV_LAST) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_LATCH;
            sd_d    = 1'b0;
            latch_d = 1'b1;
          end else begin
            sd_d     = next_bit;
            shadow_d = shadow_adv;
            shen_d   = (DIV_LAST == '0);
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
          shen_d    = ((div_cnt_q + 1'b1) == DIV_LAST);
        end
      end
      S_LATCH: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        sd_d      = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        sd_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      ready_q   <= 1'b0;
      sd_q      <= 1'b0;
      shen_q    <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      ready_q   <= ready_d;
      sd_q      <= sd_d;
      shen_q    <= shen_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_sd       = sd_q;
  assign o_shift_en = shen_q;
  assign o_latch    = latch_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: two instances (DIV=1 MSB-first, DIV=3 LSB-first) checked
// cycle by cycle against a timing-formula model plus a 4-stage chain model.
module tb_shift_load_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       valid_a = 1'b0, abort_a = 1'b0;
  logic [3:0] data_a = '0;
  logic       rdy_a, sd_a, shen_a, lat_a, busy_a;
  logic       valid_b = 1'b0, abort_b = 1'b0;
  logic [3:0] data_b = '0;
  logic       rdy_b, sd_b, shen_b, lat_b, busy_b;

  int tests_run = 0;
  int tests_failed = 0;

  shift_load_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .i_data(data_a), .i_abort(abort_a),
    .o_ready(rdy_a), .o_sd(sd_a), .o_shift_en(shen_a), .o_latch(lat_a), .o_busy(busy_a)
  );

  shift_load_ctrl #(.WIDTH(4), .DIV(3), .MSB_FIRST(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .i_data(data_b), .i_abort(abort_b),
    .o_ready(rdy_b), .o_sd(sd_b), .o_shift_en(shen_b), .o_latch(lat_b), .o_busy(busy_b)
  );

  // Model of the downstream 4-stage chain: samples o_sd on every shift_en edge.
  logic [3:0] chain_a, chain_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_a <= '0;
      chain_b <= '0;
    end else begin
      if (shen_a) chain_a <= {chain_a[2:0], sd_a};
      if (shen_b) chain_b <= {chain_b[2:0], sd_b};
    end
  end

  function automatic logic [4:0] obs(input int sel);
    return (sel != 0) ? {rdy_b, busy_b, sd_b, shen_b, lat_b} : {rdy_a, busy_a, sd_a, shen_a, lat_a};
  endfunction

  function automatic int div_of(input int sel);
    return (sel != 0) ? 3 : 1;
  endfunction

  // Expected {ready,busy,sd,shen,latch} in cycle c after the acceptance edge.
  // abort_c: cycle during which i_abort is held high (0 = none).
  function automatic logic [4:0] model(input logic [3:0] d, input int sel, input int c, input int abort_c);
    int div, k;
    logic b;
    div = div_of(sel);
    if (abort_c > 0 && abort_c <= 4 * div && c > abort_c) return 5'b10000;
    if (c >= 1 && c <= 4 * div) begin
      k = (c - 1) / div;
      b = (sel != 0) ? d[k] : d[3 - k];
      return {1'b0, 1'b1, b, (c % div) == 0, 1'b0};
    end
    if (c == 4 * div + 1) return 5'b01001;
    return 5'b10000;
  endfunction

  function automatic logic [3:0] taps_of(input logic [3:0] d, input int sel);
    logic [3:0] t;
    t = '0;
    for (int k = 0; k < 4; k++) t = {t[2:0], (sel != 0) ? d[k] : d[3 - k]};
    return t;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [3:0] d, input logic ab);
    if (sel != 0) begin valid_b = v; data_b = d; abort_b = ab; end
    else          begin valid_a = v; data_a = d; abort_a = ab; end
  endtask

  // Offer one word, then check every cycle up to two cycles after ready returns.
  task automatic run_word(input int sel, input logic [3:0] d, input int abort_c, input string name);
    int n, div, last;
    logic [4:0] e, o;
    logic [3:0] ch;
    div = div_of(sel);
    last = 4 * div + 3;
    n = 0;
    while (obs(sel)[4] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (obs(sel)[4] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_wait got=%b exp=1", name, obs(sel)[4]);
    end
    set_in(sel, 1'b1, d, 1'b0);
    @(posedge clk); #1;
    set_in(sel, 1'b0, ~d, 1'b0);
    for (int c = 1; c <= last; c++) begin
      e = model(d, sel, c, abort_c);
      o = obs(sel);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s c=%0d {rdy,busy,sd,shen,latch} got=%b exp=%b", name, c, o, e);
      end
      if (c == 4 * div + 1 && !(abort_c > 0 && abort_c <= 4 * div)) begin
        ch = (sel != 0) ? chain_b : chain_a;
        tests_run++;
        if (ch !== taps_of(d, sel)) begin
          tests_failed++;
          $display("FAIL %s taps got=%b exp=%b", name, ch, taps_of(d, sel));
        end
      end
      set_in(sel, 1'b0, ~d, c == abort_c);
      if (c < last) begin @(posedge clk); #1; end
    end
    set_in(sel, 1'b0, ~d, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({obs(0), obs(1)} !== 10'b0) begin
        tests_failed++;
        $display("FAIL reset_hold got=%b exp=%b", {obs(0), obs(1)}, 10'b0);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({obs(0), obs(1)} !== 10'b1000010000) begin
      tests_failed++;
      $display("FAIL reset_release got=%b exp=%b", {obs(0), obs(1)}, 10'b1000010000);
    end
  endtask

  task automatic test_basic;
    run_word(0, 4'b1011, 0, "basic_msb_div1");
  endtask

  task automatic test_divided;
    run_word(1, 4'b0110, 0, "lsb_div3");
  endtask

  task automatic test_back_to_back;
    logic [4:0] e;
    set_in(0, 1'b1, 4'hA, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b1, 4'h5, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      e = (c <= 6) ? model(4'hA, 0, c, 0) : model(4'h5, 0, c - 6, 0);
      tests_run++;
      if (obs(0) !== e) begin
        tests_failed++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, obs(0), e);
      end
      if (c == 5 || c == 11) begin
        tests_run++;
        if (chain_a !== ((c == 5) ? 4'hA : 4'h5)) begin
          tests_failed++;
          $display("FAIL b2b_taps c=%0d got=%h exp=%h", c, chain_a, (c == 5) ? 4'hA : 4'h5);
        end
      end
      if (c == 7) set_in(0, 1'b0, 4'h0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort;
    run_word(0, 4'b1101, 2, "abort_c2");
    run_word(0, 4'b0111, 0, "after_abort");
    run_word(1, 4'b1111, 12, "abort_final_shift");
    run_word(1, 4'b1001, 13, "abort_in_latch");
    run_word(0, 4'b0101, 6, "abort_in_idle");
  endtask

  task automatic test_reset_mid_shift;
    set_in(0, 1'b1, 4'hF, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (obs(0) !== 5'b01110) begin
      tests_failed++;
      $display("FAIL rst_mid_pre got=%b exp=%b", obs(0), 5'b01110);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs(0) !== 5'b00000) begin
      tests_failed++;
      $display("FAIL rst_mid_async got=%b exp=%b", obs(0), 5'b00000);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (obs(0) !== 5'b00000) begin
        tests_failed++;
        $display("FAIL rst_mid_hold got=%b exp=%b", obs(0), 5'b00000);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (obs(0) !== 5'b10000) begin
      tests_failed++;
      $display("FAIL rst_mid_release got=%b exp=%b", obs(0), 5'b10000);
    end
    run_word(0, 4'h9, 0, "after_rst_mid");
  endtask

  task automatic test_random;
    int sel, div, ab;
    logic [3:0] d;
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 1));
      div = div_of(sel);
      d = 4'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * div + 2)) : 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_word(sel, d, ab, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divided();
    test_back_to_back();
    test_abort();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
